// File: rtl/price_display_pkg.sv
// Shared types and constants for the price display path (LEADING_ZERO_BLANK_EN
// selects leading-digit blanking in price_display).
package price_display_pkg;

    typedef enum logic [1:0] {IDLE, CONV, DONE} state_t;

    localparam int NUM_DIGITS = 4;
    localparam int PRICE_W    = 14;

    // Segment order {g,f,e,d,c,b,a}, active-low
    localparam logic [6:0] SEG_0     = 7'b1000000;
    localparam logic [6:0] SEG_1     = 7'b1111001;
    localparam logic [6:0] SEG_2     = 7'b0100100;
    localparam logic [6:0] SEG_3     = 7'b0110000;
    localparam logic [6:0] SEG_4     = 7'b0011001;
    localparam logic [6:0] SEG_5     = 7'b0010010;
    localparam logic [6:0] SEG_6     = 7'b0000010;
    localparam logic [6:0] SEG_7     = 7'b1111000;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0010000;
    localparam logic [6:0] SEG_DASH  = 7'b0111111;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    function automatic logic [6:0] seg_code(input logic [3:0] d);
        case (d)
            4'd0:    return SEG_0;
            4'd1:    return SEG_1;
            4'd2:    return SEG_2;
            4'd3:    return SEG_3;
            4'd4:    return SEG_4;
            4'd5:    return SEG_5;
            4'd6:    return SEG_6;
            4'd7:    return SEG_7;
            4'd8:    return SEG_8;
            4'd9:    return SEG_9;
            default: return SEG_BLANK;
        endcase
    endfunction

    function automatic logic [15:0] bcd_add3(input logic [15:0] v);
        logic [15:0] r;
        r = v;
        for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
            if (r[4*i +: 4] >= 4'd5)
                r[4*i +: 4] = r[4*i +: 4] + 4'd3;
        end
        return r;
    endfunction

endpackage

// File: rtl/price_display_bin2bcd_seq.sv
// Sequential double-dabble converter: start captures bin, 14 shift-add-3
// iterations, then a one-cycle done pulse with the BCD result held on bcd.
module bin2bcd_seq
    import price_display_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [PRICE_W-1:0] bin,
    output logic               busy,
    output logic               done,
    output logic [15:0]        bcd,
    output logic               big
);

    state_t             state;
    logic [PRICE_W-1:0] shreg;
    logic [PRICE_W-1:0] captured;
    logic [3:0]         iter;
    logic [15:0]        adj;

    always_comb adj = bcd_add3(bcd);

    assign big = (captured > PRICE_W'(9999));

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            busy     <= 1'b0;
            done     <= 1'b0;
            shreg    <= '0;
            captured <= '0;
            bcd      <= '0;
            iter     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        shreg    <= bin;
                        captured <= bin;
                        bcd      <= '0;
                        iter     <= '0;
                        busy     <= 1'b1;
                        state    <= CONV;
                    end
                end
                CONV: begin
                    bcd   <= {adj[14:0], shreg[PRICE_W-1]};
                    shreg <= {shreg[PRICE_W-2:0], 1'b0};
                    iter  <= iter + 4'd1;
                    if (iter == 4'(PRICE_W - 1)) begin
                        state <= DONE;
                        done  <= 1'b1;
                    end
                end
                DONE: begin
                    // start is deliberately not sampled here
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: rtl/price_display.sv
// Price display top: BCD conversion of precof and a multiplexed "EE.CC"
// 7-segment scan. Define LEADING_ZERO_BLANK_EN to blank a leading zero digit.
module price_display
    import price_display_pkg::*;
#(
    parameter int REFRESH_BITS = 16,
    parameter int DP_DIGIT     = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [PRICE_W-1:0] precof,
    input  logic               load,
    output logic               busy,
    output logic               valid,
    output logic               ovf,
    output logic [3:0]         an,
    output logic [6:0]         seg,
    output logic               dp
);

    localparam logic [1:0] DP_SEL = 2'(DP_DIGIT);

    logic [15:0]             eng_bcd;
    logic                    eng_done;
    logic                    eng_big;
    logic [15:0]             digits;
    logic [REFRESH_BITS-1:0] scan;
    logic                    lit;
    logic [1:0]              k;
    logic [3:0]              digit;

    bin2bcd_seq u_conv (
        .clk   (clk),
        .rst   (rst),
        .start (load),
        .bin   (precof),
        .busy  (busy),
        .done  (eng_done),
        .bcd   (eng_bcd),
        .big   (eng_big)
    );

    assign valid = eng_done;

    // lit keeps the panel dark in the first cycle after reset
    always_ff @(posedge clk) begin
        if (rst) begin
            digits <= '0;
            ovf    <= 1'b0;
            scan   <= '0;
            lit    <= 1'b0;
        end else begin
            scan <= scan + 1'b1;
            lit  <= 1'b1;
            if (eng_done) begin
                digits <= eng_bcd;
                ovf    <= eng_big;
            end
        end
    end

    always_comb begin
        k     = scan[REFRESH_BITS-1 -: 2];
        digit = digits[{k, 2'b00} +: 4];
        an    = '1;
        seg   = SEG_BLANK;
        dp    = 1'b1;
        if (lit) begin
            an  = ~(4'b0001 << k);
            seg = ovf ? SEG_DASH : seg_code(digit);
            dp  = !((k == DP_SEL) && !ovf);
`ifdef LEADING_ZERO_BLANK_EN
            if ((DP_DIGIT < 3) && (k == 2'd3) && (digit == 4'd0) && !ovf)
                seg = SEG_BLANK;
`endif
        end
    end

endmodule

// File: tb/tb_price_display.sv
// Scoreboard bench for price_display with a short scan counter (REFRESH_BITS=4).
module tb_price_display;
    import price_display_pkg::*;

    typedef struct {
        logic [15:0] bcd;
        logic        big;
        int          vcyc;
    } exp_t;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic [PRICE_W-1:0] precof = '0;
    logic               load = 1'b0;
    logic               busy, valid, ovf, dp;
    logic [3:0]         an;
    logic [6:0]         seg;

    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    exp_t sb[$];

    logic [6:0] segtab [0:9] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                                 7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                                 7'b0000000, 7'b0010000};

    price_display #(.REFRESH_BITS(4), .DP_DIGIT(2)) dut (
        .clk(clk), .rst(rst), .precof(precof), .load(load), .busy(busy),
        .valid(valid), .ovf(ovf), .an(an), .seg(seg), .dp(dp)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got %h want %h (cycle %0d)", name, got, want, cyc);
        end
    endtask

    // Watches 16 scan cycles: one active digit, correct code, dp and step order
    task automatic check_scan(input logic [15:0] bcd, input logic big);
        int prevk = -1;
        int run = 0;
        bit full = 0;
        for (int i = 0; i < 16; i++) begin
            int k, zeros;
            logic [3:0] d;
            logic [6:0] want;
            @(negedge clk);
            if (i == 0) check("ovf_flag", 32'(ovf), 32'(big));
            zeros = 0;
            k = 0;
            for (int b = 0; b < 4; b++) if (an[b] == 1'b0) begin zeros++; k = b; end
            check("an_onehot", 32'(zeros), 32'd1);
            d = bcd[4*k +: 4];
            if (big) want = 7'b0111111;
            else if (d < 4'd10) want = segtab[d];
            else want = 7'b1111111;
`ifdef LEADING_ZERO_BLANK_EN
            if (!big && k == 3 && d == 4'd0) want = 7'b1111111;
`endif
            check($sformatf("seg_digit%0d", k), 32'(seg), 32'(want));
            check($sformatf("dp_digit%0d", k), 32'(dp), (k == 2 && !big) ? 32'd0 : 32'd1);
            if (prevk >= 0 && k != prevk) begin
                check("scan_order", 32'(k), 32'((prevk + 1) % 4));
                if (full) check("scan_dwell", 32'(run), 32'd4);
                full = 1;
                run = 0;
            end
            run++;
            prevk = k;
        end
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (valid === 1'b1) begin
                if (sb.size() == 0) begin
                    check("unexpected_valid", 32'd1, 32'd0);
                end else begin
                    e = sb.pop_front();
                    check("valid_latency", 32'(cyc), 32'(e.vcyc));
                    check("busy_at_valid", 32'(busy), 32'd1);
                    check_scan(e.bcd, e.big);
                end
            end
        end
    end

    // Loads v, checks busy window; optionally pulses a second load at offset ign_off
    task automatic run_conv(input logic [13:0] v, input logic [15:0] eb, input logic eo,
                            input int ign_off, input logic [13:0] iv);
        exp_t e;
        @(negedge clk);
        precof = v;
        load = 1'b1;
        e.bcd = eb; e.big = eo; e.vcyc = cyc + 15;
        sb.push_back(e);
        for (int off = 1; off <= 16; off++) begin
            @(negedge clk);
            check($sformatf("busy_off%0d", off), 32'(busy), (off <= 15) ? 32'd1 : 32'd0);
            load = (off == ign_off);
            if (off == ign_off) precof = iv;
        end
        load = 1'b0;
        repeat (20) @(negedge clk);
    endtask

    initial begin : stim
        repeat (2) @(negedge clk);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_valid", 32'(valid), 32'd0);
        check("rst_ovf", 32'(ovf), 32'd0);
        check("rst_an", 32'(an), 32'hF);
        check("rst_seg", 32'(seg), 32'h7F);
        check("rst_dp", 32'(dp), 32'd1);
        rst = 1'b0;

        run_conv(14'd1234,  16'h1234, 1'b0, 0, '0);
        run_conv(14'd9999,  16'h9999, 1'b0, 0, '0);
        run_conv(14'd10000, 16'h0000, 1'b1, 0, '0);
        run_conv(14'd500,   16'h0500, 1'b0, 5, 14'd77);
        run_conv(14'd0,     16'h0000, 1'b0, 15, 14'd42);
        run_conv(14'd16383, 16'h0000, 1'b1, 0, '0);
        run_conv(14'd5,     16'h0005, 1'b0, 0, '0);

        // reset in the middle of a conversion
        @(negedge clk);
        precof = 14'd4321;
        load = 1'b1;
        for (int off = 1; off <= 7; off++) begin
            @(negedge clk);
            load = 1'b0;
        end
        rst = 1'b1;
        sb.delete();
        @(negedge clk);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_valid", 32'(valid), 32'd0);
        check("abort_an", 32'(an), 32'hF);
        check("abort_seg", 32'(seg), 32'h7F);
        check("abort_dp", 32'(dp), 32'd1);
        rst = 1'b0;
        check_scan(16'h0000, 1'b0);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("abort_no_busy", 32'(busy), 32'd0);
        end

        check("scoreboard_drained", 32'(sb.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/price_display.md
Name: price_display

Overview:
- Consumer end of the scale's price path: captures the 14-bit price in cents (precof) from the price calculator on a load strobe.
- Converts the value to 4 BCD digits with a sequential shift-add-3 (double-dabble) engine.
- Drives a time-multiplexed 4-digit 7-segment display as "EE.CC" (euros.cents).
- Sits between the price calculator and the board's display pins.

Parameters:
- REFRESH_BITS, 16, width of the scan counter; each digit is lit for 2^(REFRESH_BITS-2) cycles.
- DP_DIGIT, 2, digit index (0 = rightmost) whose decimal point is lit.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- precof  in  14  price in cents, unsigned.
- load  in  1  one-cycle capture strobe for precof.
- busy  out  1  conversion in progress.
- valid  out  1  one-cycle pulse when new digits are latched for display.
- ovf  out  1  latched price > 9999.
- an  out  4  digit enables, active-low; an[0] is the rightmost digit.
- seg  out  7  {g,f,e,d,c,b,a}, active-low.
- dp  out  1  decimal point, active-low.

Behaviour:
- Reset values (one cycle of rst=1): busy=0, valid=0, ovf=0, an=4'b1111, seg=7'b1111111, dp=1, display digits=0000, scan counter=0, FSM=IDLE.
- FSM states and transitions:
  - IDLE: load=1 captures precof into a shift register, clears the BCD accumulator, sets iteration count=0, moves to CONV.
  - CONV: each cycle, add 3 to every BCD nibble >=5, then shift {bcd, bin} left by 1. After 14 iterations, go to DONE.
  - DONE: one cycle. Latches the BCD result into the display digit register, pulses valid=1, sets ovf=(captured value>9999), returns to IDLE.
- Latency and busy:
  - load in cycle N gives valid in cycle N+15; the display shows the new value from cycle N+16.
  - busy=1 from N+1 through N+15 inclusive.
- Boundary conditions:
  - load while busy=1: ignored, no queueing. The captured value is unchanged.
  - load in the same cycle as the DONE state: ignored. A new capture is possible from the next IDLE cycle.
  - The display keeps the previous digits throughout a conversion.
  - rst during CONV: the conversion is aborted and all outputs take reset values the next cycle.
- Overflow (ovf=1): all four digits show '-' (seg=7'b0111111), dp=1. ovf clears on the next conversion with a value <=9999.
- Scan:
  - The free-running counter starts in the cycle after reset.
  - counter[REFRESH_BITS-1:REFRESH_BITS-2] selects digit k; an has exactly one zero, at bit k.
  - seg shows the 7-segment code of digit k. dp=0 only when k==DP_DIGIT and ovf=0.
  - The counter wraps modulo 2^REFRESH_BITS.
- Digit codes: 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000.
- Arithmetic: precof is unsigned. Values 10000..16383 are flagged, never truncated. The BCD accumulator is 16 bits; the iteration counter is 4 bits.

Optional Feature:
- Macro: LEADING_ZERO_BLANK_EN.
- When defined, digit 3 is blanked (seg=7'b1111111, its an still scanned) if it is 0 and ovf=0. Digits at or right of DP_DIGIT are never blanked; e.g. 5 cents displays " 0.05".
- When undefined, all four digits are always shown, e.g. "00.05".

Decomposition:
- Package price_display_pkg holds:
  - the state typedef (IDLE, CONV, DONE);
  - the 7-segment digit-code constants, SEG_DASH and SEG_BLANK;
  - NUM_DIGITS=4 and PRICE_W=14.
- One sub-module, bin2bcd_seq, contains the capture/CONV/DONE engine with a start/busy/done handshake.
- The top level keeps the display register, overflow flag, scan counter and segment decode.

Test Plan:
- Reset then load precof=1234 → busy for 15 cycles, valid pulse at N+15. Scan shows an=1110/seg '4', 1101/'3', 1011/'2' with dp=0, 0111/'1'.
- load precof=9999 then precof=10000 (after valid) → first conversion gives digits 9,9,9,9 with ovf=0. Second gives ovf=1, all digits '-', dp=1 throughout the scan.
- load 500, then pulse load with 77 at N+5 (busy) → the 77 load is ignored, display shows "05.00" (or " 5.00" with LEADING_ZERO_BLANK_EN).
- load 4321, assert rst at N+7 → next cycle busy=0, an=1111, seg=1111111, no valid pulse. The display then scans 0000.
- load 0 → valid at N+15, all digits '0' (digit 3 blank with LEADING_ZERO_BLANK_EN), dp=0 only on digit 2.
- With REFRESH_BITS=4 → an steps 1110→1101→1011→0111 every 4 cycles and wraps after 16 cycles.
